// File: rtl/flags_cond_unit_pkg.sv
// Shared types and constants for the NZCV flag register and condition evaluator.
package flags_cond_unit_pkg;

    typedef enum logic [3:0] {
        CondEq = 4'h0,
        CondNe = 4'h1,
        CondCs = 4'h2,
        CondCc = 4'h3,
        CondMi = 4'h4,
        CondPl = 4'h5,
        CondVs = 4'h6,
        CondVc = 4'h7,
        CondHi = 4'h8,
        CondLs = 4'h9,
        CondGe = 4'hA,
        CondLt = 4'hB,
        CondGt = 4'hC,
        CondLe = 4'hD,
        CondAl = 4'hE,
        CondNv = 4'hF
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // ALU ports arrive as {Neg, Z, O, Ca}; the register order is {N, Z, C, V}.
    function automatic flags_t alu_to_flags(input logic neg, input logic z, input logic ca,
                                            input logic o);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = neg;
        f[FLAG_Z] = z;
        f[FLAG_C] = ca;
        f[FLAG_V] = o;
        return flags_t'(f);
    endfunction

endpackage

// File: rtl/flags_cond_unit_cond_eval.sv
// Combinational condition-code check of a 4-bit code against an NZCV value.
module flags_cond_unit_cond_eval
    import flags_cond_unit_pkg::*;
(
    input  flags_t flags_i,
    input  cond_e  cond_i,
    output logic   pass_o
);

    always_comb begin
        pass_o = 1'b0;
        case (cond_i)
            CondEq: pass_o = flags_i.z;
            CondNe: pass_o = !flags_i.z;
            CondCs: pass_o = flags_i.c;
            CondCc: pass_o = !flags_i.c;
            CondMi: pass_o = flags_i.n;
            CondPl: pass_o = !flags_i.n;
            CondVs: pass_o = flags_i.v;
            CondVc: pass_o = !flags_i.v;
            CondHi: pass_o = flags_i.c && !flags_i.z;
            CondLs: pass_o = !flags_i.c || flags_i.z;
            CondGe: pass_o = (flags_i.n == flags_i.v);
            CondLt: pass_o = (flags_i.n != flags_i.v);
            CondGt: pass_o = !flags_i.z && (flags_i.n == flags_i.v);
            CondLe: pass_o = flags_i.z || (flags_i.n != flags_i.v);
            CondAl: pass_o = 1'b1;
            CondNv: pass_o = 1'b0;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/flags_cond_unit.sv
// Architectural NZCV register with shadow copy, condition evaluation stage over a
// valid/ready handshake, and saturating executed/skipped counters.
module flags_cond_unit
    import flags_cond_unit_pkg::*;
#(
    parameter int unsigned TAG_W = 8,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned FWD   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flag_we,
    input  logic             neg_in,
    input  logic             z_in,
    input  logic             o_in,
    input  logic             ca_in,
    input  logic             save_req,
    input  logic             restore_req,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_cond,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_exec,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] skip_cnt,
    input  logic             clr_cnt
);

    flags_t           arch_q, arch_d;
    flags_t           shadow_q, shadow_d;
    flags_t           alu_flags, eval_flags;
    logic             pass, accept;
    logic             out_valid_q, out_valid_d;
    logic             out_exec_q, out_exec_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
    logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;

    assign alu_flags = alu_to_flags(neg_in, z_in, ca_in, o_in);

    // Evaluate against the value flags_q will hold after this edge (when forwarding).
    always_comb begin
        eval_flags = arch_q;
        if (restore_req) begin
            eval_flags = shadow_q;
        end else if ((FWD != 0) && flag_we) begin
            eval_flags = alu_flags;
        end
    end

    flags_cond_unit_cond_eval u_cond_eval (
        .flags_i (eval_flags),
        .cond_i  (cond_e'(in_cond)),
        .pass_o  (pass)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        arch_d      = arch_q;
        shadow_d    = shadow_q;
        out_valid_d = out_valid_q;
        out_exec_d  = out_exec_q;
        out_tag_d   = out_tag_q;
        exec_cnt_d  = exec_cnt_q;
        skip_cnt_d  = skip_cnt_q;

        if (restore_req) begin
            arch_d = shadow_q;
        end else if (flag_we) begin
            arch_d = alu_flags;
        end
        // Reads the pre-edge arch_q, so save+restore swaps the two registers.
        if (save_req) begin
            shadow_d = arch_q;
        end

        if (accept) begin
            out_valid_d = 1'b1;
            out_exec_d  = pass;
            out_tag_d   = in_tag;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (clr_cnt) begin
            exec_cnt_d = '0;
            skip_cnt_d = '0;
        end else if (accept) begin
            if (pass && (exec_cnt_q != '1)) begin
                exec_cnt_d = exec_cnt_q + CNT_W'(1);
            end
            if (!pass && (skip_cnt_q != '1)) begin
                skip_cnt_d = skip_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arch_q      <= '0;
            shadow_q    <= '0;
            out_valid_q <= 1'b0;
            out_exec_q  <= 1'b0;
            out_tag_q   <= '0;
            exec_cnt_q  <= '0;
            skip_cnt_q  <= '0;
        end else begin
            arch_q      <= arch_d;
            shadow_q    <= shadow_d;
            out_valid_q <= out_valid_d;
            out_exec_q  <= out_exec_d;
            out_tag_q   <= out_tag_d;
            exec_cnt_q  <= exec_cnt_d;
            skip_cnt_q  <= skip_cnt_d;
        end
    end

    assign flags_q   = arch_q;
    assign out_valid = out_valid_q;
    assign out_exec  = out_exec_q;
    assign out_tag   = out_tag_q;
    assign exec_cnt  = exec_cnt_q;
    assign skip_cnt  = skip_cnt_q;

endmodule

// File: tb/tb_flags_cond_unit.sv
// Bench for flags_cond_unit: a forwarding instance (16-bit counters) and a non-forwarding
// instance (3-bit counters) share stimulus and are checked against a behavioural model.
module tb_flags_cond_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flag_we, neg_in, z_in, o_in, ca_in, save_req, restore_req;
    logic       in_valid, out_ready, clr_cnt;
    logic [3:0] in_cond;
    logic [7:0] in_tag;

    logic        in_ready_o[2];
    logic        out_valid_o[2];
    logic        out_exec_o[2];
    logic [7:0]  out_tag_o[2];
    logic [3:0]  flags_o[2];
    logic [15:0] ecnt_a, scnt_a;
    logic [2:0]  ecnt_b, scnt_b;
    logic [15:0] ecnt[2];
    logic [15:0] scnt[2];

    assign ecnt[0] = ecnt_a;
    assign scnt[0] = scnt_a;
    assign ecnt[1] = {13'b0, ecnt_b};
    assign scnt[1] = {13'b0, scnt_b};

    always #5 clk = ~clk;

    flags_cond_unit #(.TAG_W(8), .CNT_W(16), .FWD(1)) u_dut_fwd (
        .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .neg_in(neg_in), .z_in(z_in),
        .o_in(o_in), .ca_in(ca_in), .save_req(save_req), .restore_req(restore_req),
        .in_valid(in_valid), .in_ready(in_ready_o[0]), .in_cond(in_cond), .in_tag(in_tag),
        .out_valid(out_valid_o[0]), .out_ready(out_ready), .out_exec(out_exec_o[0]),
        .out_tag(out_tag_o[0]), .flags_q(flags_o[0]), .exec_cnt(ecnt_a), .skip_cnt(scnt_a),
        .clr_cnt(clr_cnt)
    );

    flags_cond_unit #(.TAG_W(8), .CNT_W(3), .FWD(0)) u_dut_nofwd (
        .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .neg_in(neg_in), .z_in(z_in),
        .o_in(o_in), .ca_in(ca_in), .save_req(save_req), .restore_req(restore_req),
        .in_valid(in_valid), .in_ready(in_ready_o[1]), .in_cond(in_cond), .in_tag(in_tag),
        .out_valid(out_valid_o[1]), .out_ready(out_ready), .out_exec(out_exec_o[1]),
        .out_tag(out_tag_o[1]), .flags_q(flags_o[1]), .exec_cnt(ecnt_b), .skip_cnt(scnt_b),
        .clr_cnt(clr_cnt)
    );

    // Reference model state, index 0 = forwarding instance, 1 = non-forwarding.
    logic [3:0] m_flags[2];
    logic [3:0] m_shadow[2];
    logic       m_valid[2];
    logic       m_exec[2];
    logic [7:0] m_tag[2];
    int         m_ecnt[2];
    int         m_scnt[2];
    int         cmax[2];
    int         n_cmp = 0;
    int         n_bad = 0;

    // Flags given as {N,Z,C,V}.
    function automatic logic cond_ok(input logic [3:0] f, input logic [3:0] c);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_flags[k] = 4'h0; m_shadow[k] = 4'h0; m_valid[k] = 1'b0;
            m_exec[k] = 1'b0; m_tag[k] = 8'h0; m_ecnt[k] = 0; m_scnt[k] = 0;
        end
    endtask

    task automatic idle();
        flag_we = 0; neg_in = 0; z_in = 0; o_in = 0; ca_in = 0; save_req = 0;
        restore_req = 0; in_valid = 0; out_ready = 1; clr_cnt = 0; in_cond = 4'h0;
        in_tag = 8'h0;
    endtask

    task automatic set_alu(input logic [3:0] nzcv);
        neg_in = nzcv[3]; z_in = nzcv[2]; ca_in = nzcv[1]; o_in = nzcv[0];
    endtask

    // Advances one clock, updating the model from the inputs present before the edge.
    task automatic step();
        logic [3:0] nf[2], ns[2], alu, eff;
        logic       nv[2], ne[2], acc, p;
        logic [7:0] nt[2];
        int         nec[2], nsc[2];
        alu = {neg_in, z_in, ca_in, o_in};
        for (int k = 0; k < 2; k++) begin
            eff = restore_req ? m_shadow[k] : ((k == 0) && flag_we) ? alu : m_flags[k];
            acc = in_valid && (!m_valid[k] || out_ready);
            p   = cond_ok(eff, in_cond);
            nf[k] = restore_req ? m_shadow[k] : flag_we ? alu : m_flags[k];
            ns[k] = save_req ? m_flags[k] : m_shadow[k];
            nv[k] = acc ? 1'b1 : out_ready ? 1'b0 : m_valid[k];
            ne[k] = acc ? p : m_exec[k];
            nt[k] = acc ? in_tag : m_tag[k];
            nec[k] = m_ecnt[k];
            nsc[k] = m_scnt[k];
            if (clr_cnt) begin
                nec[k] = 0; nsc[k] = 0;
            end else if (acc && p) begin
                nec[k] = (m_ecnt[k] < cmax[k]) ? m_ecnt[k] + 1 : cmax[k];
            end else if (acc) begin
                nsc[k] = (m_scnt[k] < cmax[k]) ? m_scnt[k] + 1 : cmax[k];
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            m_flags[k] = nf[k]; m_shadow[k] = ns[k]; m_valid[k] = nv[k];
            m_exec[k] = ne[k]; m_tag[k] = nt[k]; m_ecnt[k] = nec[k]; m_scnt[k] = nsc[k];
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if ({flags_o[k], out_valid_o[k], out_exec_o[k], out_tag_o[k]} !== 15'h0) begin
                n_bad++;
                $display("FAIL reset_state dut%0d: flags=%b valid=%b exec=%b tag=%h want 0",
                         k, flags_o[k], out_valid_o[k], out_exec_o[k], out_tag_o[k]);
            end
            n_cmp++;
            if (ecnt[k] !== 16'd0 || scnt[k] !== 16'd0) begin
                n_bad++;
                $display("FAIL reset_counters dut%0d: exec=%0d skip=%0d want 0/0",
                         k, ecnt[k], scnt[k]);
            end
        end
        @(negedge clk);
        rst_n = 1;
        step();
        in_valid = 1; in_cond = 4'hE; in_tag = 8'h11;
        step();
        idle();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (out_valid_o[k] !== 1'b1 || out_exec_o[k] !== 1'b1 || ecnt[k] !== 16'd1) begin
                n_bad++;
                $display("FAIL first_al dut%0d: valid=%b exec=%b ecnt=%0d want 1/1/1",
                         k, out_valid_o[k], out_exec_o[k], ecnt[k]);
            end
        end
    endtask

    task automatic test_forward();
        flag_we = 1; set_alu(4'b0100);
        in_valid = 1; in_cond = 4'h0; in_tag = 8'h22;
        step();
        idle();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (flags_o[k] !== 4'b0100) begin
                n_bad++;
                $display("FAIL fwd_flags dut%0d: got %b want 0100", k, flags_o[k]);
            end
            n_cmp++;
            if (out_exec_o[k] !== ((k == 0) ? 1'b1 : 1'b0)) begin
                n_bad++;
                $display("FAIL fwd_exec dut%0d: got %b want %b", k, out_exec_o[k], k == 0);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_bb[4];
        exp_bb = '{1'b0, 1'b1, 1'b0, 1'b1};
        flag_we = 1; set_alu(4'b1000);
        step();
        idle();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_cond = 4'(10 + i); in_tag = 8'(i + 8'h40);
            step();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (out_valid_o[k] !== 1'b1 || out_exec_o[k] !== exp_bb[i] ||
                    out_tag_o[k] !== 8'(i + 8'h40) || in_ready_o[k] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b cond%0h dut%0d: v=%b e=%b t=%h r=%b want 1/%b/%h/1",
                             10 + i, k, out_valid_o[k], out_exec_o[k], out_tag_o[k],
                             in_ready_o[k], exp_bb[i], 8'(i + 8'h40));
                end
            end
        end
        idle();
        step();
    endtask

    task automatic test_stall();
        flag_we = 1; set_alu(4'b0100);
        step();
        idle();
        in_valid = 1; in_cond = 4'h0; in_tag = 8'h5A;
        step();
        out_ready = 0; in_tag = 8'h33; in_cond = 4'h1;
        for (int i = 0; i < 3; i++) begin
            flag_we = 1; set_alu(4'(i));
            step();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (out_valid_o[k] !== 1'b1 || out_exec_o[k] !== 1'b1 ||
                    out_tag_o[k] !== 8'h5A || in_ready_o[k] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL stall%0d dut%0d: v=%b e=%b t=%h r=%b want 1/1/5a/0",
                             i, k, out_valid_o[k], out_exec_o[k], out_tag_o[k],
                             in_ready_o[k]);
                end
            end
        end
        idle();
        step();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (out_valid_o[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_drain dut%0d: valid=%b want 0", k, out_valid_o[k]);
            end
        end
    endtask

    task automatic test_shadow();
        flag_we = 1; set_alu(4'b0010);
        step();
        idle(); save_req = 1;
        step();
        idle(); flag_we = 1; set_alu(4'b1101);
        step();
        idle(); restore_req = 1; flag_we = 1; set_alu(4'b1111);
        in_valid = 1; in_cond = 4'h1; in_tag = 8'h77;
        step();
        idle();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (flags_o[k] !== 4'b0010 || out_exec_o[k] !== 1'b1) begin
                n_bad++;
                $display("FAIL restore dut%0d: flags=%b exec=%b want 0010/1",
                         k, flags_o[k], out_exec_o[k]);
            end
        end
        flag_we = 1; set_alu(4'b1111);
        step();
        idle(); save_req = 1; restore_req = 1;
        step();
        idle();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (flags_o[k] !== 4'b0010) begin
                n_bad++;
                $display("FAIL swap_flags dut%0d: got %b want 0010", k, flags_o[k]);
            end
        end
        restore_req = 1;
        step();
        idle();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (flags_o[k] !== 4'b1111) begin
                n_bad++;
                $display("FAIL swap_shadow dut%0d: got %b want 1111", k, flags_o[k]);
            end
        end
    endtask

    task automatic test_saturate();
        clr_cnt = 1;
        step();
        idle();
        in_valid = 1; in_cond = 4'hF;
        for (int i = 0; i < 9; i++) begin
            in_tag = 8'(i);
            step();
            if (i >= 5) begin
                n_cmp++;
                if (scnt[1] !== 16'((i + 1 > 7) ? 7 : i + 1) || scnt[0] !== 16'(i + 1)) begin
                    n_bad++;
                    $display("FAIL skip_sat n=%0d: got %0d/%0d want %0d/%0d", i + 1, scnt[0],
                             scnt[1], i + 1, (i + 1 > 7) ? 7 : i + 1);
                end
            end
        end
        clr_cnt = 1; in_cond = 4'hE;
        step();
        idle();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (ecnt[k] !== 16'd0 || scnt[k] !== 16'd0 || out_exec_o[k] !== 1'b1) begin
                n_bad++;
                $display("FAIL clr_prio dut%0d: exec=%0d skip=%0d out=%b want 0/0/1",
                         k, ecnt[k], scnt[k], out_exec_o[k]);
            end
        end
    endtask

    task automatic test_midflight_reset();
        in_valid = 1; in_cond = 4'hE; in_tag = 8'hC3; out_ready = 0;
        step();
        idle();
        #2 rst_n = 0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (out_valid_o[k] !== 1'b0 || ecnt[k] !== 16'd0 || flags_o[k] !== 4'h0) begin
                n_bad++;
                $display("FAIL async_reset dut%0d: valid=%b ecnt=%0d flags=%b want 0",
                         k, out_valid_o[k], ecnt[k], flags_o[k]);
            end
        end
        @(negedge clk);
        rst_n = 1;
        step();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (out_valid_o[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL no_replay dut%0d: valid=%b want 0", k, out_valid_o[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            flag_we     = ($urandom_range(1) == 1);
            set_alu(4'($urandom_range(15)));
            save_req    = ($urandom_range(9) == 0);
            restore_req = ($urandom_range(9) == 0);
            in_valid    = ($urandom_range(9) < 7);
            out_ready   = ($urandom_range(9) < 7);
            clr_cnt     = ($urandom_range(49) == 0);
            in_cond     = 4'($urandom_range(15));
            in_tag      = 8'($urandom_range(255));
            step();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (flags_o[k] !== m_flags[k] || out_valid_o[k] !== m_valid[k] ||
                    in_ready_o[k] !== (!m_valid[k] || out_ready) ||
                    ecnt[k] !== 16'(m_ecnt[k]) || scnt[k] !== 16'(m_scnt[k]) ||
                    (m_valid[k] && (out_exec_o[k] !== m_exec[k] ||
                                    out_tag_o[k] !== m_tag[k]))) begin
                    n_bad++;
                    $display({"FAIL random%0d dut%0d: f=%b v=%b r=%b e=%b t=%h ec=%0d sc=%0d",
                              " want f=%b v=%b e=%b t=%h ec=%0d sc=%0d"},
                             i, k, flags_o[k], out_valid_o[k], in_ready_o[k], out_exec_o[k],
                             out_tag_o[k], ecnt[k], scnt[k], m_flags[k], m_valid[k],
                             m_exec[k], m_tag[k], m_ecnt[k], m_scnt[k]);
                end
            end
        end
        idle();
    endtask

    initial begin
        cmax[0] = 65535;
        cmax[1] = 7;
        test_reset();
        test_forward();
        test_back_to_back();
        test_stall();
        test_shadow();
        test_saturate();
        test_midflight_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/flags_cond_unit.md
Name: flags_cond_unit

Overview:
- Consumer end of the ALU flag interface: latches the Neg/Z/O/Ca flags produced by the ALU flag generator into an architectural NZCV register.
- Evaluates 4-bit condition codes of instructions against that register and returns an execute/skip decision over a valid/ready pipeline stage.
- Holds a shadow copy of the flags for exception entry and return, plus saturating executed/skipped counters for debug.
- Sits between the decode stage and the execute/writeback enable logic of the processor.

Parameters:
- TAG_W, 8, width of the opaque instruction tag carried alongside each condition.
- CNT_W, 16, width of each saturating statistics counter.
- FWD, 1, 1 = a flag write in the same cycle is forwarded into the condition evaluation; 0 = evaluation uses only the registered flags.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flag_we  in  1  latch ALU flags this cycle.
- neg_in  in  1  ALU Neg flag.
- z_in  in  1  ALU Z flag.
- o_in  in  1  ALU overflow (V) flag.
- ca_in  in  1  ALU carry (C) flag.
- save_req  in  1  copy flags_q into the shadow register.
- restore_req  in  1  copy the shadow register into flags_q.
- in_valid  in  1  condition request valid.
- in_ready  out  1  unit can accept a request.
- in_cond  in  4  condition code.
- in_tag  in  TAG_W  request tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_exec  out  1  1 = condition passed, execute; 0 = skip.
- out_tag  out  TAG_W  tag of the result.
- flags_q  out  4  architectural flags, ordered {N,Z,C,V}.
- exec_cnt  out  CNT_W  executed count, saturating.
- skip_cnt  out  CNT_W  skipped count, saturating.
- clr_cnt  in  1  synchronous clear of both counters.

Behaviour:
- Reset (asynchronous, on rst_n low) clears flags_q, the shadow register, out_valid, out_exec, out_tag, exec_cnt and skip_cnt to 0. Outputs hold these values for as long as rst_n is low.
- A reset asserted mid-operation drops any in-flight result. No result is replayed after reset.

Flag register update priority, per cycle:
- restore_req wins: flags_q <= shadow.
- Otherwise, if flag_we: flags_q <= {neg_in, z_in, ca_in, o_in}.
- Otherwise flags_q holds.
- save_req always captures the flags_q value from before the edge, so save and write in the same cycle save the old flags.
- save_req and restore_req in the same cycle: flags_q takes the old shadow and the shadow takes the old flags_q (swap).

Effective flags for evaluation:
- If FWD = 1 and flag_we = 1 and restore_req = 0: the incoming ALU flags.
- If restore_req = 1: the shadow value, regardless of FWD.
- Otherwise: flags_q.

Condition codes:
- 0 EQ: Z
- 1 NE: !Z
- 2 CS: C
- 3 CC: !C
- 4 MI: N
- 5 PL: !N
- 6 VS: V
- 7 VC: !V
- 8 HI: C & !Z
- 9 LS: !C | Z
- A GE: N == V
- B LT: N != V
- C GT: !Z & (N == V)
- D LE: Z | (N != V)
- E AL: 1
- F NV: 0 (reserved, never executes)

Handshake:
- Single output register. in_ready = !out_valid | out_ready.
- Accept when in_valid & in_ready. Latency is 1 cycle: the result appears on the following edge with out_valid = 1.
- When there is no accept and out_ready = 1, out_valid clears.
- out_exec and out_tag hold stable while out_valid = 1 and out_ready = 0.
- The condition is evaluated at accept time; flag changes during a stall do not alter the held result.

Counters:
- On each accept, exec_cnt or skip_cnt increments by one according to the computed result. Each saturates at all ones.
- clr_cnt has priority over an increment in the same cycle.

Decomposition:
- Shared package holds:
  - the cond_e enum (EQ..NV, 4 bits);
  - the flags_t packed struct {n, z, c, v};
  - the FLAG_* bit-index constants.
- One sub-module: cond_eval (combinational flags_t × cond_e → pass). The parent contains all sequential logic.

Test Plan:
- Reset then idle -> flags_q = 0000, out_valid = 0, counters 0. in_cond = E accepted -> next cycle out_exec = 1, exec_cnt = 1.
- flag_we with z_in = 1 and in_cond = 0 in the same cycle, FWD = 1 -> out_exec = 1, flags_q = 0100. Same stimulus with FWD = 0 from reset -> out_exec = 0.
- flags_q = 1000 (N = 1, V = 0), conds A, B, C, D back-to-back with out_ready = 1 -> out_exec = 0, 1, 0, 1 on consecutive cycles, one per cycle.
- out_ready held 0 for 3 cycles with tag 0x5A pending -> out_valid, out_exec and out_tag stable, in_ready = 0, flag_we during the stall does not change out_exec.
- flags_q = 0010, save_req, then flag_we to 1101, then restore_req with flag_we = 1 in the same cycle -> flags_q = 0010. Simultaneous save_req and restore_req swaps the values.
- Preset skip_cnt to all ones minus 1, issue three NV requests -> skip_cnt saturates at all ones. clr_cnt together with an accept -> both counters 0.
